// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared constants, state enum and mapping for the sequence checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

   localparam logic [2:0] C_CODE_S0 = 3'b000;
   localparam logic [2:0] C_CODE_S1 = 3'b011;
   localparam logic [2:0] C_CODE_S2 = 3'b101;
   localparam logic [2:0] C_CODE_S3 = 3'b110;
   localparam logic [2:0] C_CODE_S4 = 3'b010;

   localparam logic [2:0] C_IDX_S0 = 3'd0;
   localparam logic [2:0] C_IDX_S1 = 3'd1;
   localparam logic [2:0] C_IDX_S2 = 3'd2;
   localparam logic [2:0] C_IDX_S3 = 3'd3;
   localparam logic [2:0] C_IDX_S4 = 3'd4;

   localparam logic [2:0] C_SUCC_S0 = C_CODE_S1;
   localparam logic [2:0] C_SUCC_S1 = C_CODE_S2;
   localparam logic [2:0] C_SUCC_S2 = C_CODE_S3;
   localparam logic [2:0] C_SUCC_S3 = C_CODE_S4;
   localparam logic [2:0] C_SUCC_S4 = C_CODE_S0;

   typedef enum logic [0:0] {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } state_t;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_decode.sv
// ============================================================================
// Module  : seq_decode
// Brief   : Combinational map of a counter code to {legal, index, successor}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_decode
   import seq_pkg::*;
(
   input  logic [2:0] code,
   output logic       legal,
   output logic [2:0] index,
   output logic [2:0] successor
);

   always_comb begin
      legal     = 1'b1;
      index     = C_IDX_S0;
      successor = C_SUCC_S0;
      case (code)
         C_CODE_S0: begin index = C_IDX_S0; successor = C_SUCC_S0; end
         C_CODE_S1: begin index = C_IDX_S1; successor = C_SUCC_S1; end
         C_CODE_S2: begin index = C_IDX_S2; successor = C_SUCC_S2; end
         C_CODE_S3: begin index = C_IDX_S3; successor = C_SUCC_S3; end
         C_CODE_S4: begin index = C_IDX_S4; successor = C_SUCC_S4; end
         // 001, 100 and 111 never appear in the legal sequence
         default:   legal = 1'b0;
      endcase
   end

endmodule : seq_decode

`default_nettype wire

// File: rtl/seq_checker.sv
// ============================================================================
// Module  : seq_checker
// Brief   : Tracks a 5-step counter sequence, flags violations, counts laps.
//           Macro SEQ_CHECK_ERRCNT_EN enables the saturating error counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_checker
   import seq_pkg::*;
#(
   parameter int LAP_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   input  logic [2:0]       in_count,
   output logic             locked,
   output logic [2:0]       index,
   output logic             seq_err,
   output logic             lap_done,
   output logic [LAP_W-1:0] lap_count,
   output logic [7:0]       err_count
);

   state_t           state_q,     state_d;
   logic [2:0]       expected_q,  expected_d;
   logic [2:0]       index_q,     index_d;
   logic             seq_err_q,   seq_err_d;
   logic             lap_done_q,  lap_done_d;
   logic [LAP_W-1:0] lap_count_q, lap_count_d;

   logic       dec_legal;
   logic [2:0] dec_index;
   logic [2:0] dec_succ;

   seq_decode u_decode (
      .code      (in_count),
      .legal     (dec_legal),
      .index     (dec_index),
      .successor (dec_succ)
   );

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      index_d     = index_q;
      seq_err_d   = 1'b0;
      lap_done_d  = 1'b0;
      lap_count_d = lap_count_q;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_count == C_CODE_S0) begin
                  state_d    = TRACK;
                  expected_d = C_CODE_S1;
                  index_d    = C_IDX_S0;
               end
            end
            TRACK: begin
               if (dec_legal && (in_count == expected_q)) begin
                  index_d    = dec_index;
                  expected_d = dec_succ;
                  if (in_count == C_CODE_S0) begin
                     lap_done_d  = 1'b1;
                     lap_count_d = lap_count_q + LAP_W'(1);
                  end
               end else begin
                  // A stray 000 is a valid restart point, so resync immediately
                  seq_err_d  = 1'b1;
                  index_d    = C_IDX_S0;
                  expected_d = C_CODE_S1;
                  state_d    = (in_count == C_CODE_S0) ? TRACK : HUNT;
               end
            end
            default: begin
               state_d    = HUNT;
               expected_d = C_CODE_S1;
               index_d    = C_IDX_S0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= HUNT;
         expected_q  <= C_CODE_S1;
         index_q     <= C_IDX_S0;
         seq_err_q   <= 1'b0;
         lap_done_q  <= 1'b0;
         lap_count_q <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         index_q     <= index_d;
         seq_err_q   <= seq_err_d;
         lap_done_q  <= lap_done_d;
         lap_count_q <= lap_count_d;
      end
   end

`ifdef SEQ_CHECK_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (seq_err_d && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_count_q <= 8'd0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'd0;
`endif

   assign locked    = (state_q == TRACK);
   assign index     = index_q;
   assign seq_err   = seq_err_q;
   assign lap_done  = lap_done_q;
   assign lap_count = lap_count_q;

endmodule : seq_checker

`default_nettype wire

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter LAP_W, default 8, width of the completed-lap counter.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 SHALL have port in_valid  input  1  qualifies in_count for this cycle.
REQ-005 SHALL have port in_count  input  3  observed counter value, legal sequence 000->011->101->110->010->000.
REQ-006 SHALL have port locked  output  1  high while tracking the sequence.
REQ-007 SHALL have port index  output  3  position of last accepted value: 000=0, 011=1, 101=2, 110=3, 010=4.
REQ-008 SHALL have port seq_err  output  1  one-cycle pulse on a sequence violation.
REQ-009 SHALL have port lap_done  output  1  one-cycle pulse on completion of 010->000.
REQ-010 SHALL have port lap_count  output  LAP_W  completed laps, modulo 2^LAP_W.
REQ-011 SHALL have port err_count  output  8  saturating violation count.

Function
REQ-012 SHALL implement FSM states HUNT and TRACK, plus an internal 3-bit expected-value register.
REQ-013 SHALL update state and outputs only on CLK rising edges where in_valid=1, except that pulses clear on any edge; when in_valid=0, locked, index, lap_count, and err_count SHALL hold.
REQ-014 In HUNT, in_count=000 SHALL move to TRACK with expected=011 and index=0; any other value SHALL be ignored, with no seq_err.
REQ-015 In TRACK, in_count==expected SHALL update index, advance expected to the sequence successor, and stay in TRACK.
REQ-016 In TRACK, an accepted 000 reached from 010 SHALL pulse lap_done and increment lap_count, with 2^LAP_W-1 wrapping to 0.
REQ-017 In TRACK, in_count!=expected SHALL pulse seq_err and increment err_count.
REQ-018 On that mismatch, if in_count=000 the block SHALL re-enter TRACK with expected=011 and index=0; otherwise it SHALL go to HUNT with index=0.
REQ-019 Codes 001, 100 and 111 SHALL never be accepted.
REQ-020 locked SHALL equal (state==TRACK).
REQ-021 All outputs SHALL be registered, visible one cycle after the sampling edge.
REQ-022 seq_err and lap_done SHALL be mutually exclusive, each high for exactly one cycle per event.
REQ-023 err_count SHALL saturate at 255.

Reset
REQ-024 RESET=1 SHALL force HUNT, expected=011, locked=0, index=0, seq_err=0, lap_done=0, lap_count=0, err_count=0 on the next CLK edge.
REQ-025 RESET SHALL take priority over a simultaneous in_valid; a reset mid-lap SHALL discard partial progress.

Configuration
REQ-026 SHALL provide macro SEQ_CHECK_ERRCNT_EN.
REQ-027 When SEQ_CHECK_ERRCNT_EN is defined, err_count SHALL behave per REQ-017 and REQ-023.
REQ-028 When SEQ_CHECK_ERRCNT_EN is undefined, err_count SHALL be constant 0 and no counter register SHALL be synthesised; seq_err is unaffected.

Structure
REQ-029 Package seq_pkg SHALL hold the five sequence codes as named 3-bit constants, the FSM state enum (HUNT, TRACK), and the successor and index mapping constants.
REQ-030 A combinational sub-module seq_decode SHALL map in_count to {legal, index[2:0], successor[2:0]}; seq_checker SHALL instantiate it once.

Verification
REQ-031 Reset, then valid 000,011,101,110,010,000 -> locked=1 from the first sample, index 0,1,2,3,4,0, one lap_done, lap_count=1, err_count=0.
REQ-032 In TRACK after 011, present 110 -> seq_err pulse, err_count=1, locked=0; then 000 -> locked=1, index=0.
REQ-033 In TRACK, present 000 instead of expected 101 -> seq_err pulse and locked stays 1, expected=011.
REQ-034 Valid stream with in_valid deasserted between samples -> outputs hold; results identical to the back-to-back case.
REQ-035 Run 256 clean laps with LAP_W=8 -> lap_count wraps to 0; then 300 violations -> err_count=255 (macro defined) or 0 (macro undefined).
REQ-036 Assert RESET together with in_valid=1, in_count=000 mid-lap -> next cycle HUNT, all outputs at reset values.
